fft_result_collector: RTL and testbench

- Downstream stage of the FFT accelerator.
- Captures each complex output sample (accel_dout_r/accel_dout_i, qualified by accel_out_en) into an on-chip FIFO.
- Exposes the FIFO to the RS5 core as a small memory-mapped register window on the data bus.
- Lets firmware drain one transform frame after the core raises accel_en, and reports frame completion and overflow.

---
 rtl/fft_collect_pkg.sv | 14 +
 rtl/fft_result_fifo.sv | 49 ++++
 rtl/fft_result_collector.sv | 118 +++++++++++
 tb/tb_fft_result_collector.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/fft_collect_pkg.sv
// fft_collect_pkg: shared FSM state, register offsets and bit positions for the FFT result collector.
package fft_collect_pkg;
  typedef enum logic [1:0] {IDLE, COLLECT, DONE} collect_state_e;
  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL = 2'd2;
  localparam int ST_OVF = 31;
  localparam int ST_DONE = 30;
  localparam int ST_FULL = 29;
  localparam int ST_EMPTY = 28;
  localparam int CTRL_FLUSH = 0;
  localparam int CTRL_CLR = 1;
  localparam int CTRL_MASK = 2;
endpackage

// File: rtl/fft_result_fifo.sv
// fft_result_fifo: synchronous FIFO; a push into a full FIFO is accepted only alongside a pop, otherwise dropped.
module fft_result_fifo #(
  parameter int W = 32,
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  logic [W-1:0]  wdata_i,
  output logic          full_o,
  output logic          empty_o,
  output logic          drop_o,
  output logic [CW-1:0] count_o,
  output logic [W-1:0]  head_o
);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic push, pop;
  assign full_o = cnt_q == CW'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign pop = pop_i && !empty_o && !flush_i;
  assign push = push_i && (!full_o || pop) && !flush_i;
  assign drop_o = push_i && !push && !flush_i;
  assign count_o = cnt_q;
  assign head_o = mem_q[rd_q];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_q + AW'(push);
      rd_q <= rd_q + AW'(pop);
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= wdata_i;
  end
endmodule

// File: rtl/fft_result_collector.sv
// fft_result_collector: buffers FFT output samples in a FIFO behind a 4-register bus window.
// Optional FFT_COLLECT_IRQ_EN adds a maskable irq_o pulse on frame_done/overflow rise.
import fft_collect_pkg::*;
module fft_result_collector #(
  parameter int DATA_W = 16,
  parameter int DEPTH = 64,
  parameter int FRAME_LEN = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0002_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              accel_en,
  input  logic              accel_out_en,
  input  logic [DATA_W-1:0] accel_dout_r,
  input  logic [DATA_W-1:0] accel_dout_i,
  input  logic              bus_en_i,
  input  logic [3:0]        bus_we_i,
  input  logic [31:0]       bus_addr_i,
  input  logic [31:0]       bus_wdata_i,
  output logic [31:0]       bus_rdata_o,
  output logic              bus_hit_o,
  output logic              frame_done_o
`ifdef FFT_COLLECT_IRQ_EN
  , output logic            irq_o
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;
  collect_state_e state_q, state_d;
  logic [15:0] cnt_q, cnt_d, n_cnt;
  logic en_q, ovf_q, ovf_d, done_q, done_d, hit_q, done_set;
  logic [31:0] rdata_q, rdata_d, status;
  logic hit, rd, ctrl_wr, flush, clr, rise, push, pop, full, empty, drop;
  logic [1:0] off;
  logic [CW-1:0] count;
  logic [2*DATA_W-1:0] head;
  logic unused_ok;
  assign hit = bus_en_i && bus_addr_i[31:4] == BASE_ADDR[31:4];
  assign off = bus_addr_i[3:2];
  assign rd = hit && bus_we_i == '0;
  assign ctrl_wr = hit && bus_we_i != '0 && off == REG_CTRL;
  assign flush = ctrl_wr && bus_wdata_i[CTRL_FLUSH];
  assign clr = ctrl_wr && bus_wdata_i[CTRL_CLR];
  assign rise = accel_en && !en_q;
  assign pop = rd && off == REG_DATA;
  assign push = state_q == COLLECT && accel_out_en;
  assign unused_ok = ^{bus_wdata_i[31:3], bus_wdata_i[CTRL_MASK], bus_addr_i[1:0]};
  fft_result_fifo #(.W(2 * DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push_i(push), .pop_i(pop), .flush_i(flush),
    .wdata_i({accel_dout_r, accel_dout_i}), .full_o(full), .empty_o(empty),
    .drop_o(drop), .count_o(count), .head_o(head)
  );
  // A rising accel_en inside COLLECT restarts the count, still counting this cycle's sample.
  assign n_cnt = (rise ? 16'd0 : cnt_q) + 16'(accel_out_en);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    done_set = 1'b0;
    if (flush) state_d = IDLE;
    else if (state_q == COLLECT) begin
      cnt_d = n_cnt;
      if (accel_out_en && n_cnt == 16'(FRAME_LEN)) begin
        state_d = DONE;
        done_set = 1'b1;
      end
    end else if (rise) begin
      state_d = COLLECT;
      cnt_d = '0;
    end
  end
  assign ovf_d = drop || (ovf_q && !clr);
  assign done_d = done_set || (done_q && !clr);
  always_comb begin
    status = '0;
    status[ST_OVF] = ovf_q;
    status[ST_DONE] = done_q;
    status[ST_FULL] = full;
    status[ST_EMPTY] = empty;
    status[15:0] = 16'(count);
    rdata_d = !rd ? '0
            : off == REG_DATA ? (empty ? '0 : {16'(head[2*DATA_W-1:DATA_W]), 16'(head[DATA_W-1:0])})
            : off == REG_STATUS ? status : '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      en_q <= 1'b0;
      ovf_q <= 1'b0;
      done_q <= 1'b0;
      rdata_q <= '0;
      hit_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      en_q <= accel_en;
      ovf_q <= ovf_d;
      done_q <= done_d;
      rdata_q <= rdata_d;
      hit_q <= hit;
    end
  end
  assign bus_rdata_o = rdata_q;
  assign bus_hit_o = hit_q;
  assign frame_done_o = done_q;
`ifdef FFT_COLLECT_IRQ_EN
  logic mask_q, irq_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      mask_q <= ctrl_wr ? bus_wdata_i[CTRL_MASK] : mask_q;
      irq_q <= !mask_q && ((done_d && !done_q) || (ovf_d && !ovf_q));
    end
  end
  assign irq_o = irq_q;
`endif
endmodule

// File: tb/tb_fft_result_collector.sv
// tb_fft_result_collector: directed and random stimulus checked against a queue-based model of the collector.
module tb_fft_result_collector;
  localparam int DEPTH = 64;
  localparam int FRAME_LEN = 64;
  localparam logic [31:0] BASE = 32'h0002_0000;
  logic clk = 0, rst = 1, accel_en = 0, accel_out_en = 0, bus_en_i = 0;
  logic [15:0] accel_dout_r = 0, accel_dout_i = 0;
  logic [3:0] bus_we_i = 0;
  logic [31:0] bus_addr_i = 0, bus_wdata_i = 0, bus_rdata_o;
  logic bus_hit_o, frame_done_o;
`ifdef FFT_COLLECT_IRQ_EN
  logic irq_o;
`endif
  int n_vec = 0, n_err = 0;
  logic ae = 0;
  logic [31:0] mq [$];
  int m_mode, m_cnt;
  logic m_ovf, m_done, m_prev, m_mask;
  always #5 clk = ~clk;
  fft_result_collector #(.DATA_W(16), .DEPTH(DEPTH), .FRAME_LEN(FRAME_LEN), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .accel_en(accel_en), .accel_out_en(accel_out_en),
    .accel_dout_r(accel_dout_r), .accel_dout_i(accel_dout_i), .bus_en_i(bus_en_i),
    .bus_we_i(bus_we_i), .bus_addr_i(bus_addr_i), .bus_wdata_i(bus_wdata_i),
    .bus_rdata_o(bus_rdata_o), .bus_hit_o(bus_hit_o), .frame_done_o(frame_done_o)
`ifdef FFT_COLLECT_IRQ_EN
    , .irq_o(irq_o)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    mq.delete();
    m_mode = 0;
    m_cnt = 0;
    m_ovf = 0;
    m_done = 0;
    m_prev = 0;
    m_mask = 0;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    #1;
    chk("rst_hit", {31'b0, bus_hit_o}, 0);
    chk("rst_rdata", bus_rdata_o, 0);
    chk("rst_done", {31'b0, frame_done_o}, 0);
`ifdef FFT_COLLECT_IRQ_EN
    chk("rst_irq", {31'b0, irq_o}, 0);
`endif
    model_reset();
    @(negedge clk);
    rst = 0;
  endtask
  task automatic step(input logic oe, input logic [15:0] r, input logic [15:0] im, input logic ben,
                      input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wd);
    logic hit, rd, wr, flush, clr, rise, sdone, sovf, eirq;
    logic [1:0] off;
    logic [31:0] er;
    @(negedge clk);
    accel_en = ae;
    accel_out_en = oe;
    accel_dout_r = r;
    accel_dout_i = im;
    bus_en_i = ben;
    bus_we_i = we;
    bus_addr_i = addr;
    bus_wdata_i = wd;
    hit = ben && addr[31:4] == BASE[31:4];
    off = addr[3:2];
    rd = hit && we == 0;
    wr = hit && we != 0;
    er = 0;
    if (rd && off == 0 && mq.size() > 0) er = mq[0];
    if (rd && off == 1) er = {m_ovf, m_done, mq.size() == DEPTH, mq.size() == 0, 12'b0, 16'(mq.size())};
    flush = wr && off == 2 && wd[0];
    clr = wr && off == 2 && wd[1];
    rise = ae && !m_prev;
    m_prev = ae;
    sdone = 0;
    sovf = 0;
    if (flush) begin
      mq.delete();
      m_mode = 0;
    end else begin
      if (rd && off == 0 && mq.size() > 0) void'(mq.pop_front());
      if (m_mode == 1 && oe) begin
        if (mq.size() < DEPTH) mq.push_back({r, im});
        else sovf = 1;
      end
      if (m_mode == 1) begin
        m_cnt = (rise ? 0 : m_cnt) + int'(oe);
        if (oe && m_cnt == FRAME_LEN) begin
          m_mode = 2;
          sdone = 1;
        end
      end else if (rise) begin
        m_mode = 1;
        m_cnt = 0;
      end
    end
    eirq = !m_mask && ((sdone && !m_done) || (sovf && !m_ovf));
    m_done = sdone || (m_done && !clr);
    m_ovf = sovf || (m_ovf && !clr);
    if (wr && off == 2) m_mask = wd[2];
    @(posedge clk);
    #1;
    chk("hit", {31'b0, bus_hit_o}, {31'b0, hit});
    chk("rdata", bus_rdata_o, er);
    chk("frame_done", {31'b0, frame_done_o}, {31'b0, m_done});
`ifdef FFT_COLLECT_IRQ_EN
    chk("irq", {31'b0, irq_o}, {31'b0, eirq});
`endif
  endtask
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic sample(input logic [15:0] r, input logic [15:0] im);
    step(1, r, im, 0, 0, 0, 0);
  endtask
  task automatic reg_rd(input logic [3:0] o);
    step(0, 0, 0, 1, 4'h0, BASE | 32'(o), 0);
  endtask
  task automatic reg_wr(input logic [31:0] v);
    step(0, 0, 0, 1, 4'hF, BASE | 32'h8, v);
  endtask
  task automatic start_frame();
    ae = 0;
    idle(1);
    ae = 1;
    idle(1);
  endtask
  initial begin
    model_reset();
    do_reset();
    for (int k = 0; k < 5; k++) sample(16'(k + 1), 16'(k + 7));
    reg_rd(4);
    reg_rd(0);
    start_frame();
    for (int k = 0; k < 64; k++) sample(16'(k), 16'(-k));
    reg_rd(4);
    for (int k = 0; k < 64; k++) reg_rd(0);
    reg_rd(4);
    reg_wr(2);
    start_frame();
    for (int k = 0; k < 64; k++) sample(16'(k + 100), 16'(k * 3));
    start_frame();
    for (int k = 0; k < 6; k++) sample(16'hAA00 + 16'(k), 16'h5500);
    reg_rd(4);
    step(1, 16'hBEEF, 16'hCAFE, 1, 4'h0, BASE, 0);
    reg_rd(4);
    for (int k = 0; k < 65; k++) reg_rd(0);
    reg_wr(2);
    start_frame();
    for (int k = 0; k < 10; k++) sample(16'(k), 16'(k));
    reg_wr(3);
    reg_rd(4);
    for (int k = 0; k < 5; k++) sample(16'h1111, 16'h2222);
    reg_rd(4);
    reg_wr(4);
    start_frame();
    for (int k = 0; k < 64; k++) sample(16'(k), 16'(k));
    reg_wr(3);
    start_frame();
    for (int k = 0; k < 5; k++) sample(16'(k), 16'(k));
    do_reset();
    reg_rd(4);
    reg_rd(12);
    step(0, 0, 0, 1, 4'h0, BASE + 32'h10, 0);
    for (int k = 0; k < 4000; k++) begin
      logic [31:0] a, wd;
      logic [3:0] we;
      if ($urandom_range(0, 40) == 0) ae = ~ae;
      a = ($urandom_range(0, 9) == 0) ? $urandom : BASE | 32'($urandom_range(0, 15));
      we = ($urandom_range(0, 30) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      wd = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 7)) & 32'h6;
      step(1'($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom),
           1'($urandom_range(0, 2) == 0), we, a, wd);
      if (k == 2000) do_reset();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
